// File: rtl/arb_pkg.sv
// Shared definitions for the system bus arbiter.
//   - FSM state encoding (arb_state_t)
//   - requester count, watchdog width and default watchdog limit
package arb_pkg;

  localparam int NUM_REQ         = 4;
  localparam int WD_W            = 8;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01,
    ARB_TURN = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_priority4.sv
// Combinational rotate-priority picker for four requesters.
// The search starts one past last_owner (mod 4); the first set req bit wins.
// Ports:
//   req        in  [3:0]  request vector
//   last_owner in  [1:0]  most recent owner; lowest priority this round
//   win        out [3:0]  one-hot winner (all zero when no request)
//   win_id     out [1:0]  binary index of the winner
//   any_req    out        at least one request pending
module rr_priority4 (
  input  logic [3:0] req,
  input  logic [1:0] last_owner,
  output logic [3:0] win,
  output logic [1:0] win_id,
  output logic       any_req
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    win     = '0;
    win_id  = 2'd0;
    any_req = |req;
    found   = 1'b0;
    idx     = last_owner;
    for (int i = 1; i <= 4; i++) begin
      // 2-bit add wraps naturally, giving last_owner+1 .. last_owner+4 (mod 4)
      idx = last_owner + 2'(i);
      if (!found && req[idx]) begin
        found       = 1'b1;
        win[idx]    = 1'b1;
        win_id      = idx;
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Four-requester round-robin arbiter/sequencer for the shared system bus.
// Holds a grant for a whole transaction, inserts one turnaround cycle
// between owners and revokes a hung owner with a watchdog.
// Ports:
//   clk          in        system clock, rising edge
//   reset        in        asynchronous active-low reset
//   req          in  [3:0] level request per requester
//   done         in  [3:0] one-cycle transaction-complete pulse per requester
//   gnt          out [3:0] registered one-hot grant (bus mux select)
//   gnt_id       out [1:0] binary owner index, meaningful while bus_busy
//   bus_busy     out       a grant is active
//   timeout_err  out       one-cycle pulse when the watchdog revokes a grant
//
// state    | meaning
// ARB_IDLE | no owner, waiting for any request
// ARB_BUSY | owner holds the bus until its done or watchdog expiry
// ARB_TURN | one dead cycle with gnt=0 before the next owner
module sys_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ     = arb_pkg::NUM_REQ,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               bus_busy,
  output logic               timeout_err
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_t      state;
  logic [1:0]      last_owner;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_nxt;
  logic            wd_expire;
  logic            owner_done;

  logic [3:0]      win;
  logic [1:0]      win_id;
  logic            any_req;

  rr_priority4 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .win        (win),
    .win_id     (win_id),
    .any_req    (any_req)
  );

  // Expiry is judged on the value the counter would take this edge, so the
  // grant made at edge G is revoked at edge G+TIMEOUT_CYC-1.
  assign wd_nxt     = wd_cnt + WD_W'(1);
  assign wd_expire  = (wd_nxt == WD_LAST);
  assign owner_done = done[gnt_id];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      gnt         <= '0;
      gnt_id      <= 2'd0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
      last_owner  <= 2'd3;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE, ARB_TURN: begin
          if (any_req) begin
            state      <= ARB_BUSY;
            gnt        <= win;
            gnt_id     <= win_id;
            last_owner <= win_id;
            bus_busy   <= 1'b1;
            wd_cnt     <= '0;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          // done takes precedence over a simultaneous watchdog expiry
          if (owner_done) begin
            state    <= ARB_TURN;
            gnt      <= '0;
            bus_busy <= 1'b0;
          end else if (wd_expire) begin
            state       <= ARB_TURN;
            gnt         <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_nxt;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          gnt      <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
